// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READ,
    FIN
  } state_t;

  function automatic int words_for(input int chain_len, input int data_w);
    return (chain_len + data_w - 1) / data_w;
  endfunction

  // Bits actually used from the final word of a transfer.
  function automatic int last_word_bits(input int chain_len, input int data_w);
    return ((chain_len % data_w) == 0) ? data_w : (chain_len % data_w);
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serdes.sv
// One-word shift register with bit index: PISO for chain loading, SIPO for readback.
module ccff_word_serdes #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sipo,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  input  logic              step,
  input  logic              last_in,
  input  logic              flush,
  input  logic              pass,
  input  logic              bit_in,
  output logic              bit_out,
  output logic              word_end,
  output logic              full,
  output logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] word_next
);

  localparam int IW = $clog2(DATA_W);

  logic [DATA_W-1:0] data, data_d, base_data;
  logic [IW-1:0]     idx, idx_d, base_idx;
  logic              full_d, base_full;

  // flush empties the register before this cycle's capture, so a word can be
  // handed out and the next one started on the same edge.
  always_comb begin
    base_data = flush ? '0 : data;
    base_idx  = flush ? '0 : idx;
    base_full = flush ? 1'b0 : full;
    word_end  = (base_idx == IW'(DATA_W - 1)) || last_in;
    word_next = base_data;
    word_next[base_idx] = bit_in;
    data_d = base_data;
    idx_d  = base_idx;
    full_d = base_full;
    if (sipo) begin
      if (step) begin
        data_d = word_next;
        if (word_end) begin
          idx_d  = '0;
          full_d = !pass;
          if (pass) data_d = '0;
        end else begin
          idx_d = base_idx + IW'(1);
        end
      end
    end else begin
      if (step) begin
        if (word_end) begin
          idx_d  = '0;
          full_d = 1'b0;
        end else begin
          idx_d = base_idx + IW'(1);
        end
      end
      if (load) begin
        data_d = word_in;
        idx_d  = '0;
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data <= '0;
      idx  <= '0;
      full <= 1'b0;
    end else begin
      data <= data_d;
      idx  <= idx_d;
      full <= full_d;
    end
  end

  assign bit_out = data[idx];
  assign word    = data;

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain controller: serial load of the ccff chain from a word
// stream and non-destructive recirculating readback into a word stream.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 15,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cmd_load,
  input  logic              cmd_read,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
);

  localparam int WORDS = words_for(CHAIN_LEN, DATA_W);
  localparam int BW    = cnt_w(CHAIN_LEN);
  localparam int WW    = cnt_w(WORDS);

  state_t            state, state_d;
  logic [BW-1:0]     bits_left;
  logic [WW-1:0]     words_rem;
  logic              shift, load_w, flush, pass, take;
  logic              last_in, out_free, start;
  logic              ser_full, ser_bit, ser_end;
  logic [DATA_W-1:0] cap_word, cap_next;

  assign last_in  = (bits_left == BW'(1));
  assign out_free = !out_valid || out_ready;
  assign start    = (state == IDLE) && (cmd_load || cmd_read);

  always_comb begin
    state_d       = state;
    in_ready      = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    shift         = 1'b0;
    load_w        = 1'b0;
    flush         = 1'b0;
    pass          = 1'b0;
    take          = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_load)      state_d = LOAD;
        else if (cmd_read) state_d = READ;
      end
      LOAD: begin
        shift         = ser_full;
        in_ready      = (words_rem != '0) && (!ser_full || ser_end);
        load_w        = in_valid && in_ready;
        ccff_shift_en = shift;
        ccff_head     = shift & ser_bit;
        if (shift && last_in) state_d = FIN;
      end
      READ: begin
        // Capture register drains into the output register whenever it frees;
        // a completed word skips the capture register if the output is free.
        take          = ser_full && out_free;
        flush         = take;
        shift         = (bits_left != '0) && (!ser_full || take);
        pass          = shift && ser_end && out_free && !take;
        ccff_shift_en = shift;
        ccff_head     = shift & ccff_tail;
        if ((bits_left == '0) && !ser_full && out_free) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state     <= IDLE;
      bits_left <= '0;
      words_rem <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_d;
      if (start) begin
        bits_left <= BW'(CHAIN_LEN);
        words_rem <= WW'(WORDS);
      end else begin
        if (shift)  bits_left <= bits_left - BW'(1);
        if (load_w) words_rem <= words_rem - WW'(1);
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (take) begin
        out_data  <= cap_word;
        out_valid <= 1'b1;
      end else if (pass) begin
        out_data  <= cap_next;
        out_valid <= 1'b1;
      end
    end
  end

  ccff_word_serdes #(
    .DATA_W(DATA_W)
  ) u_serdes (
    .clk       (prog_clk),
    .rst       (prog_reset),
    .clear     (state == IDLE),
    .sipo      (state == READ),
    .load      (load_w),
    .word_in   (in_data),
    .step      (shift),
    .last_in   (last_in),
    .flush     (flush),
    .pass      (pass),
    .bit_in    (ccff_tail),
    .bit_out   (ser_bit),
    .word_end  (ser_end),
    .full      (ser_full),
    .word      (cap_word),
    .word_next (cap_next)
  );

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: attached 15-flop chain, stream-level reference
// model checked every cycle, plus literal expectations for directed cases.
module tb_ccff_chain_loader;

  localparam int L  = 15;
  localparam int DW = 8;
  localparam int NW = (L + DW - 1) / DW;

  logic          prog_clk = 1'b0;
  logic          prog_reset, cmd_load, cmd_read, in_valid, in_ready;
  logic          out_valid, out_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic          busy, done;
  logic [DW-1:0] in_data, out_data;
  logic [L-1:0]  chain;

  int checks = 0;
  int errors = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(
    .CHAIN_LEN(L),
    .DATA_W   (DW)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .cmd_load      (cmd_load),
    .cmd_read      (cmd_read),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done)
  );

  // Physical chain: chain[0] is the head flop, chain[L-1] the tail flop.
  initial chain = '0;
  assign ccff_tail = chain[L-1];
  always @(posedge prog_clk)
    if (ccff_shift_en === 1'b1) chain <= {chain[L-2:0], ccff_head};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  int           mode, last_op, acc, shifted, rshifts, handed;
  bit           armed;
  bit           q[$];
  bit           stream[$];
  logic [L-1:0] snap;

  function automatic int completed(input int s);
    return s / DW + (((s == L) && (L % DW != 0)) ? 1 : 0);
  endfunction

  // Readback order is tail first; bits past the chain end are zero.
  function automatic logic [DW-1:0] exp_word(input int k);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < DW; j++)
      if (k * DW + j < L) w[j] = snap[L-1-(k*DW+j)];
    return w;
  endfunction

  initial begin
    int           n, pend;
    bit           exp_ir, exp_sh, exp_ov;
    logic [L-1:0] expv;
    mode = 0; last_op = 0; armed = 0;
    forever begin
      @(negedge prog_clk);
      if (armed) begin
        case (mode)
          0: begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_shift_en", ccff_shift_en, 0);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_out_valid", out_valid, 0);
            if (cmd_load) begin
              mode = 1; last_op = 1; acc = 0; shifted = 0;
              q.delete(); stream.delete();
            end else if (cmd_read) begin
              mode = 2; last_op = 2; snap = chain; rshifts = 0; handed = 0;
            end
          end
          1: begin
            exp_ir = (acc < NW) && (q.size() <= 1);
            exp_sh = (q.size() > 0);
            chk("load_busy", busy, 1);
            chk("load_done", done, 0);
            chk("load_out_valid", out_valid, 0);
            chk("load_in_ready", in_ready, exp_ir);
            chk("load_shift_en", ccff_shift_en, exp_sh);
            if (exp_sh) chk("load_head", ccff_head, q[0]);
            else        chk("load_head_idle", ccff_head, 0);
            if (exp_sh) begin
              void'(q.pop_front());
              shifted++;
            end
            if (in_valid && exp_ir) begin
              n = L - acc * DW;
              if (n > DW) n = DW;
              for (int j = 0; j < n; j++) begin
                q.push_back(in_data[j]);
                stream.push_back(in_data[j]);
              end
              acc++;
            end
            if (shifted == L) mode = 3;
          end
          2: begin
            pend   = completed(rshifts) - handed;
            exp_ov = (pend > 0);
            exp_sh = (rshifts < L) && ((pend < 2) || out_ready);
            chk("read_busy", busy, 1);
            chk("read_done", done, 0);
            chk("read_in_ready", in_ready, 0);
            chk("read_out_valid", out_valid, exp_ov);
            chk("read_shift_en", ccff_shift_en, exp_sh);
            if (exp_sh) chk("read_head_recirc", ccff_head, ccff_tail);
            if (exp_ov) chk("read_out_data", out_data, exp_word(handed));
            if (exp_sh) rshifts++;
            if (exp_ov && out_ready) begin
              handed++;
              if (handed == NW) mode = 3;
            end
          end
          default: begin
            chk("fin_done", done, 1);
            chk("fin_busy", busy, 1);
            chk("fin_shift_en", ccff_shift_en, 0);
            chk("fin_in_ready", in_ready, 0);
            chk("fin_out_valid", out_valid, 0);
            if (last_op == 1) begin
              expv = '0;
              for (int p = 0; p < L; p++) expv[L-1-p] = stream[p];
              chk("load_chain_content", chain, expv);
            end else begin
              chk("read_chain_restored", chain, snap);
            end
            mode = 0;
          end
        endcase
      end
      if (prog_reset) begin
        mode  = 0;
        armed = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge prog_clk);
      if (done === 1'b1) break;
      step();
      n++;
    end
    if (n >= 200) timeout(name);
    step();
  endtask

  task automatic do_load(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input int gap, input bit rnd, input bit both, input bit poke);
    logic [DW-1:0] w[2];
    int            n;
    bit            got;
    w[0] = w0; w[1] = w1;
    cmd_load = 1'b1; cmd_read = both;
    step();
    cmd_load = 1'b0; cmd_read = 1'b0;
    for (int i = 0; i < NW; i++) begin
      n = 0; got = 0;
      in_data = w[i];
      if (i > 0 && gap > 0) begin
        in_valid = 1'b0;
        while (n < 100) begin
          @(negedge prog_clk);
          if (in_ready === 1'b1) break;
          step();
          n++;
        end
        repeat (gap) step();
      end
      cmd_read = poke && (i > 0);
      in_valid = rnd ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      while (!got && n < 200) begin
        @(negedge prog_clk);
        if (in_valid && in_ready === 1'b1) got = 1;
        step();
        n++;
        cmd_read = 1'b0;
        if (!got) in_valid = rnd ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (!got) timeout("load_word_accept");
    end
    in_valid = 1'b0;
    wait_done("load_done_wait");
  endtask

  task automatic do_read(input int rmode, output int cnt,
                         output logic [DW-1:0] g0, output logic [DW-1:0] g1);
    int n, held;
    bit fin;
    n = 0; held = 0; fin = 0; cnt = 0; g0 = '0; g1 = '0;
    cmd_read = 1'b1;
    step();
    cmd_read = 1'b0;
    while (!fin && n < 300) begin
      if (rmode == 2)      out_ready = 1'($urandom_range(0, 1));
      else if (rmode == 1) out_ready = (held >= 10);
      else                 out_ready = 1'b1;
      @(negedge prog_clk);
      if (out_valid === 1'b1 && out_ready) begin
        if (cnt == 0) g0 = out_data;
        else if (cnt == 1) g1 = out_data;
        cnt++;
      end else if (out_valid === 1'b1) begin
        held++;
      end
      if (done === 1'b1) fin = 1;
      step();
      n++;
    end
    out_ready = 1'b0;
    if (!fin) timeout("read_done_wait");
  endtask

  initial begin
    int            cnt, n, sh;
    logic [DW-1:0] g0, g1;
    bit            got;
    prog_reset = 1'b1; cmd_load = 1'b0; cmd_read = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) step();
    prog_reset = 1'b0;
    @(negedge prog_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_head", ccff_head, 0);
    step();

    // Directed load: tail->head = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0.
    do_load(8'hA5, 8'h3C, 0, 0, 0, 0);
    chk("t1_chain", chain, 15'h529E);
    do_load(8'hA5, 8'h3C, 3, 0, 0, 0);
    chk("t2_gap_chain", chain, 15'h529E);

    do_read(0, cnt, g0, g1);
    chk("t3_word_count", cnt, 2);
    chk("t3_word0", g0, 8'hA5);
    chk("t3_word1", g1, 8'h3C);
    chk("t3_chain_kept", chain, 15'h529E);

    do_read(1, cnt, g0, g1);
    chk("t4_word_count", cnt, 2);
    chk("t4_word0", g0, 8'hA5);
    chk("t4_word1", g1, 8'h3C);
    chk("t4_chain_kept", chain, 15'h529E);

    // Both commands together plus a read poke mid-load; bit 7 of 0xC3 dropped.
    do_load(8'h5A, 8'hC3, 0, 0, 1, 1);
    do_read(0, cnt, g0, g1);
    chk("t5_word0", g0, 8'h5A);
    chk("t5_word1", g1, 8'h43);

    // Reset after five shifts, then a full reload.
    cmd_load = 1'b1;
    step();
    cmd_load = 1'b0;
    in_data = 8'hFF; in_valid = 1'b1;
    sh = 0; n = 0; got = 0;
    while (sh < 5 && n < 50) begin
      @(negedge prog_clk);
      if (ccff_shift_en === 1'b1) sh++;
      if (in_valid && in_ready === 1'b1) got = 1;
      step();
      n++;
      if (got) in_valid = 1'b0;
    end
    if (sh < 5) timeout("t6_five_shifts");
    in_valid = 1'b0;
    prog_reset = 1'b1;
    step();
    prog_reset = 1'b0;
    @(negedge prog_clk);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_shift_after_rst", ccff_shift_en, 0);
    chk("t6_ready_after_rst", in_ready, 0);
    step();
    do_load(8'h96, 8'h0F, 0, 1, 0, 0);
    do_read(2, cnt, g0, g1);
    chk("t6_word0", g0, 8'h96);
    chk("t6_word1", g1, 8'h0F);

    for (int it = 0; it < 25; it++) begin
      do_load(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 2) != 0) do_read(int'($urandom_range(0, 2)), cnt, g0, g1);
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
